// File: rtl/temp_sampler_pkg.sv
// Shared definitions for the serial temperature sampler: FSM encoding and sensor frame layout.
// A frame is a 4-bit header followed by an 8-bit temperature, MSB first.
package defs;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        DONE,
        GAP
    } SAMP_STATE;

    localparam logic [3:0] SENSOR_HDR        = 4'hA;
    localparam int         SENSOR_FRAME_BITS = 12;
    localparam int         SENSOR_DATA_BITS  = 8;
    localparam int         SHIFT_HALVES      = 2 * SENSOR_FRAME_BITS;

    function automatic logic hdr_ok(input logic [SENSOR_FRAME_BITS-1:0] frame);
        return frame[SENSOR_FRAME_BITS-1:SENSOR_DATA_BITS] == SENSOR_HDR;
    endfunction

endpackage

// File: rtl/temp_avg4.sv
// 4-tap moving average of accepted samples; avg_dat_o follows the history registers with no extra delay.
// The first sample after reset fills the whole window so the average starts at that sample.
module temp_avg4 #(
    parameter type DTYPE = logic [7:0]
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_vld_i,
    input  DTYPE sample_dat_i,
    output DTYPE avg_dat_o
);

    localparam int W  = $bits(DTYPE);
    localparam int SW = W + 2;

    DTYPE           hist_q [4];
    DTYPE           hist_d [4];
    logic           primed_q;
    logic           primed_d;
    logic [SW-1:0]  sum_dat;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            hist_d[i] = hist_q[i];
        end
        primed_d = primed_q;
        if (sample_vld_i) begin
            primed_d  = 1'b1;
            hist_d[0] = sample_dat_i;
            for (int i = 1; i < 4; i++) begin
                hist_d[i] = primed_q ? hist_q[i-1] : sample_dat_i;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                hist_q[i] <= '0;
            end
            primed_q <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                hist_q[i] <= hist_d[i];
            end
            primed_q <= primed_d;
        end
    end

    assign sum_dat   = SW'(hist_q[0]) + SW'(hist_q[1]) + SW'(hist_q[2]) + SW'(hist_q[3]);
    assign avg_dat_o = DTYPE'(sum_dat >> 2);

endmodule

// File: rtl/temp_sampler.sv
// Polls a serial temperature sensor continuously; temp/tick update on the edge entering DONE, err flags bad headers.
// Define TEMP_FILTER_EN to report a 4-tap moving average instead of the raw sample.
module temp_sampler
    import defs::*;
#(
    parameter int  CLK_DIV    = 4,
    parameter int  SAMPLE_GAP = 16,
    parameter type DTYPE      = logic [7:0]
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic sdata,
    output logic sclk,
    output logic cs_n,
    output DTYPE temp,
    output logic tick,
    output logic err
);

    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST  = 16'(SAMPLE_GAP - 1);
    localparam logic [4:0]  HALF_LAST = 5'(SHIFT_HALVES - 1);

    SAMP_STATE                      state_q, state_d;
    logic [15:0]                    cnt_q, cnt_d;
    logic [4:0]                     half_q, half_d;
    logic                           sclk_q, sclk_d;
    logic [SENSOR_FRAME_BITS-1:0]   shreg_q, shreg_d;
    logic                           tick_q, tick_d;
    logic                           err_q, err_d;
    logic                           rise;
    logic                           frame_end;
    logic                           accept;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        half_d    = half_q;
        sclk_d    = sclk_q;
        shreg_d   = shreg_q;
        rise      = 1'b0;
        frame_end = 1'b0;

        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = START;
                    cnt_d   = '0;
                end
            end
            START: begin
                if (cnt_q == DIV_LAST) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    half_d  = '0;
                    sclk_d  = 1'b1;
                    rise    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            SHIFT: begin
                if (cnt_q == DIV_LAST) begin
                    cnt_d = '0;
                    if (half_q == HALF_LAST) begin
                        // last half-period is low, so sclk is already 0 here
                        state_d   = DONE;
                        sclk_d    = 1'b0;
                        frame_end = 1'b1;
                    end else begin
                        half_d = half_q + 5'd1;
                        sclk_d = ~sclk_q;
                        rise   = ~sclk_q;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE: begin
                state_d = GAP;
                cnt_d   = '0;
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = enable ? START : IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rise) begin
            shreg_d = {shreg_q[SENSOR_FRAME_BITS-2:0], sdata};
        end

        accept = frame_end && hdr_ok(shreg_q);
        tick_d = accept;
        err_d  = frame_end && !hdr_ok(shreg_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            half_q  <= '0;
            sclk_q  <= 1'b0;
            shreg_q <= '0;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            half_q  <= half_d;
            sclk_q  <= sclk_d;
            shreg_q <= shreg_d;
            tick_q  <= tick_d;
            err_q   <= err_d;
        end
    end

`ifdef TEMP_FILTER_EN
    DTYPE avg_dat;

    temp_avg4 #(
        .DTYPE (DTYPE)
    ) u_avg (
        .clk          (clk),
        .reset        (reset),
        .sample_vld_i (accept),
        .sample_dat_i (DTYPE'(shreg_q[SENSOR_DATA_BITS-1:0])),
        .avg_dat_o    (avg_dat)
    );

    assign temp = avg_dat;
`else
    DTYPE temp_q, temp_d;

    always_comb begin
        temp_d = temp_q;
        if (accept) begin
            temp_d = DTYPE'(shreg_q[SENSOR_DATA_BITS-1:0]);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            temp_q <= '0;
        end else begin
            temp_q <= temp_d;
        end
    end

    assign temp = temp_q;
`endif

    assign cs_n = !(state_q == START || state_q == SHIFT);
    assign sclk = sclk_q;
    assign tick = tick_q;
    assign err  = err_q;

endmodule

// File: tb/tb_temp_sampler.sv
// Bench for temp_sampler: a sensor model serves 12-bit frames, a reference model predicts temp/tick/err.
module tb_temp_sampler;

    localparam int CLK_DIV    = 2;
    localparam int SAMPLE_GAP = 4;
    localparam int FRAME_LOW  = CLK_DIV * 25;
    localparam int PERIOD     = FRAME_LOW + 1 + SAMPLE_GAP;

    logic        clk    = 1'b0;
    logic        reset  = 1'b0;
    logic        enable = 1'b0;
    logic        sdata  = 1'b0;
    logic        sclk;
    logic        cs_n;
    logic        tick;
    logic        err;
    logic [7:0]  temp;

    logic [11:0] frame_word = '0;
    logic [7:0]  exp_temp   = '0;
    int          n_checks   = 0;
    int          n_errors   = 0;
    int          cyc        = 0;
    int          last_rise  = 0;
    bit          have_prev  = 1'b0;
    int          last_wait  = 0;
`ifdef TEMP_FILTER_EN
    logic [7:0]  hist[$];
`endif

    temp_sampler #(
        .CLK_DIV    (CLK_DIV),
        .SAMPLE_GAP (SAMPLE_GAP),
        .DTYPE      (logic [7:0])
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .sdata  (sdata),
        .sclk   (sclk),
        .cs_n   (cs_n),
        .temp   (temp),
        .tick   (tick),
        .err    (err)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_temp = '0;
`ifdef TEMP_FILTER_EN
        hist.delete();
`endif
    endtask

    task automatic model_accept(input logic [7:0] s);
`ifdef TEMP_FILTER_EN
        int sum;
        if (hist.size() == 0) begin
            for (int i = 0; i < 4; i++) hist.push_front(s);
        end else begin
            hist.push_front(s);
            void'(hist.pop_back());
        end
        sum = 0;
        foreach (hist[i]) sum += int'(hist[i]);
        exp_temp = 8'(sum / 4);
`else
        exp_temp = s;
`endif
    endtask

    // Sensor: presents the next frame bit until the DUT's next sclk rising edge.
    int   drv_rises = 0;
    logic drv_prev  = 1'b0;
    always @(negedge clk) begin
        if (cs_n !== 1'b0) begin
            drv_rises = 0;
            drv_prev  = 1'b0;
        end else begin
            if (sclk && !drv_prev) drv_rises++;
            drv_prev = sclk;
        end
        sdata = (drv_rises < 12) ? frame_word[4'(11 - drv_rises)] : 1'b0;
    end

    // tick/err must be exclusive and appear only in the first cs_n-high cycle after a frame.
    logic mon_prev_cs = 1'b1;
    always @(negedge clk) begin
        if (reset) begin
            check_eq("tick_err_exclusive", 32'(tick & err), 32'h0);
            check_eq("pulse_outside_done", 32'((tick | err) & ~(cs_n & ~mon_prev_cs)), 32'h0);
            mon_prev_cs = cs_n;
        end else begin
            check_eq("pulse_in_reset", 32'(tick | err), 32'h0);
            mon_prev_cs = 1'b1;
        end
    end

    // mode 0: plain frame; 1: reset at 5th sclk rise; 2: drop enable at 3rd sclk rise
    task automatic run_frame(input logic [11:0] w, input int mode);
        int   t;
        int   low;
        int   rises;
        logic ps;
        bit   acc;
        frame_word = w;
        t = 0;
        while (cs_n === 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        last_wait = t;
        if (t >= 200) begin
            check_eq("cs_fall_timeout", 32'(cs_n), 32'h0);
            return;
        end
        low   = 0;
        rises = 0;
        ps    = 1'b0;
        while (cs_n === 1'b0 && low < 200) begin
            low++;
            if (sclk && !ps) rises++;
            ps = sclk;
            if (mode == 1 && rises == 5) begin
                reset = 1'b0;
                #1;
                check_eq("rst_cs_n", 32'(cs_n), 32'h1);
                check_eq("rst_sclk", 32'(sclk), 32'h0);
                check_eq("rst_temp", 32'(temp), 32'h0);
                model_clear();
                have_prev = 1'b0;
                repeat (3) @(negedge clk);
                reset = 1'b1;
                return;
            end
            if (mode == 2 && rises == 3) enable = 1'b0;
            @(negedge clk);
        end
        if (low >= 200) begin
            check_eq("cs_rise_timeout", 32'(cs_n), 32'h1);
            return;
        end
        if (have_prev) check_eq("cs_period", 32'(cyc - last_rise), 32'(PERIOD));
        last_rise = cyc;
        have_prev = (mode == 0);
        check_eq("cs_low_cycles", 32'(low), 32'(FRAME_LOW));
        check_eq("sclk_rises", 32'(rises), 32'd12);
        acc = (w[11:8] == 4'hA);
        if (acc) model_accept(w[7:0]);
        check_eq("done_tick", 32'(tick), 32'(acc));
        check_eq("done_err", 32'(err), 32'(!acc));
        check_eq("done_temp", 32'(temp), 32'(exp_temp));
        @(negedge clk);
        check_eq("post_tick", 32'(tick), 32'h0);
        check_eq("post_err", 32'(err), 32'h0);
        check_eq("post_temp", 32'(temp), 32'(exp_temp));
    endtask

    initial begin
        logic [3:0]  h;
        logic [11:0] w;
        int          quiet;
        reset  = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("reset_cs_n", 32'(cs_n), 32'h1);
        check_eq("reset_sclk", 32'(sclk), 32'h0);
        check_eq("reset_temp", 32'(temp), 32'h0);
        check_eq("reset_tick", 32'(tick), 32'h0);
        check_eq("reset_err", 32'(err), 32'h0);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("idle_no_enable", 32'(cs_n), 32'h1);

        enable = 1'b1;
        run_frame(12'hA19, 0);
        check_eq("first_start_latency", 32'(last_wait), 32'h1);
        run_frame(12'h519, 0);

        for (int i = 0; i < 24; i++) begin
            h = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hA;
            if (i % 5 == 4) h = 4'hA;
            w = {h, 8'($urandom)};
            run_frame(w, 0);
        end

        run_frame(12'hA55, 1);
        run_frame(12'hA33, 0);
        check_eq("post_reset_start_latency", 32'(last_wait), 32'h1);
        check_eq("post_reset_temp", 32'(temp), 32'(exp_temp));

        run_frame(12'hA7F, 2);
        quiet = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (cs_n !== 1'b1) quiet++;
        end
        check_eq("idle_cs_quiet", 32'(quiet), 32'h0);

        enable = 1'b1;
        run_frame({4'hA, 8'($urandom)}, 0);
        check_eq("idle_start_latency", 32'(last_wait), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
